// File: rtl/store_data_aligner_if.sv
// ============================================================================
// Module      : store_data_aligner_if
// Description : Store request and memory write-port bundle for the aligner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface store_data_aligner_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [2:0]  Type_sel;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        st_done;
    logic        st_err;

    // Pipeline side: issues requests, plays the memory, observes completion
    modport master (
        output req_valid, req_addr, req_data, Type_sel, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  st_done, st_err
    );

    // Aligner side
    modport slave (
        input  req_valid, req_addr, req_data, Type_sel, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output st_done, st_err
    );
endinterface

`default_nettype wire

// File: rtl/store_data_aligner.sv
// ============================================================================
// Module      : store_data_aligner
// Description : Aligns SB/SH/SW store data into byte lanes with strobes and
//               issues one or two word write beats on a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_data_aligner #(
    parameter int size     = 32,
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    store_data_aligner_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [size-1:0]   addr_q, addr_d;
    logic [size-1:0]   wdata_q, wdata_d;
    logic [size-1:0]   hi_data_q, hi_data_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [3:0]        hi_strb_q, hi_strb_d;
    logic              valid_q, valid_d;
    logic              cross_q, cross_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [3:0]        base_mask;
    logic [31:0]       data_mask;
    logic              legal;
    logic [63:0]       shifted;
    logic [7:0]        strb8;
    logic              crossing;

    always_comb begin
        base_mask = 4'h0;
        data_mask = 32'h0;
        legal     = 1'b1;
        case (bus.Type_sel)
            3'b000:  begin base_mask = 4'h1; data_mask = 32'h0000_00FF; end
            3'b001:  begin base_mask = 4'h3; data_mask = 32'h0000_FFFF; end
            3'b010:  begin base_mask = 4'hF; data_mask = 32'hFFFF_FFFF; end
            default: legal = 1'b0;
        endcase
    end

    // Bytes pushed past lane 3 spill into the upper half and form the second beat
    assign shifted  = {32'h0, bus.req_data & data_mask} << {bus.req_addr[1:0], 3'b000};
    assign strb8    = {4'h0, base_mask} << bus.req_addr[1:0];
    assign crossing = |strb8[7:4];

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        hi_data_d = hi_data_q;
        hi_strb_d = hi_strb_q;
        valid_d   = valid_q;
        cross_d   = cross_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (!legal || (crossing && !SPLIT_EN)) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d   = BEAT0;
                        valid_d   = 1'b1;
                        addr_d    = {bus.req_addr[31:2], 2'b00};
                        wdata_d   = shifted[31:0];
                        wstrb_d   = strb8[3:0];
                        hi_data_d = shifted[63:32];
                        hi_strb_d = strb8[7:4];
                        cross_d   = crossing;
                    end
                end
            end
            BEAT0: begin
                if (bus.mem_ready) begin
                    if (cross_q) begin
                        state_d = BEAT1;
                        addr_d  = addr_q + 32'd4;
                        wdata_d = hi_data_q;
                        wstrb_d = hi_strb_q;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            BEAT1: begin
                if (bus.mem_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= 4'h0;
            hi_data_q <= '0;
            hi_strb_q <= 4'h0;
            valid_q   <= 1'b0;
            cross_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            hi_data_q <= hi_data_d;
            hi_strb_q <= hi_strb_d;
            valid_q   <= valid_d;
            cross_q   <= cross_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.mem_valid = valid_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wstrb = wstrb_q;
    assign bus.st_done   = done_q;
    assign bus.st_err    = err_q;

endmodule

`default_nettype wire
